// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: widths, instruction field positions,
// opcodes used by the control unit, and the fetch-stage state encoding.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc_plus4} holding register.
// Captures a word that was fetched while decode was stalled.
module fetch_skid_buffer #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [PC_WIDTH-1:0]    i_pc_plus4,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [PC_WIDTH-1:0]    o_pc_plus4
);

  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_pc_plus4;

  // Clear wins over load so that a redirect discards a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
    end else if (i_clear) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, load-use stall and beq redirect.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  input  logic                   stall_d,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                   if_id_valid,
  output logic [5:0]             opcode,
  output logic [5:0]             func,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_bubble_cnt
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  fetch_state_e           r_state, w_state_next;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_if_instr;
  logic [PC_WIDTH-1:0]    r_if_pc4;
  logic                   r_if_valid;

  logic                   w_accept;
  logic [PC_WIDTH-1:0]    w_pc_plus4;
  logic                   w_load_mem, w_load_skid, w_bubble, w_skid_load;
  logic [INSTR_WIDTH-1:0] w_skid_instr;
  logic [PC_WIDTH-1:0]    w_skid_pc4;
  logic                   w_unused_tgt_lsbs;

  assign imem_req          = (r_state == S_REQ);
  assign imem_addr         = r_pc;
  assign w_accept          = imem_req && imem_ready;
  assign w_pc_plus4        = r_pc + PC_STEP;
  assign w_unused_tgt_lsbs = ^branch_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_REQ;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (branch_taken) begin
      w_state_next = S_REQ;
    end else begin
      case (r_state)
        S_REQ:   if (w_accept && stall_d) w_state_next = S_HOLD;
        S_HOLD:  if (!stall_d)            w_state_next = S_REQ;
        default: w_state_next = S_REQ;
      endcase
    end
  end

  // A redirect suppresses every IF/ID and skid update; the flush is handled below.
  always_comb begin
    w_load_mem  = 1'b0;
    w_load_skid = 1'b0;
    w_bubble    = 1'b0;
    w_skid_load = 1'b0;
    if (!branch_taken) begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            if (stall_d) w_skid_load = 1'b1;
            else         w_load_mem  = 1'b1;
          end else if (!stall_d) begin
            w_bubble = 1'b1;
          end
        end
        S_HOLD:  if (!stall_d) w_load_skid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_pc <= RESET_PC;
    else if (branch_taken) r_pc <= {branch_target[PC_WIDTH-1:2], 2'b00};
    else if (w_accept)     r_pc <= w_pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_instr <= NOP_INSTR;
      r_if_pc4   <= '0;
      r_if_valid <= 1'b0;
    end else if (branch_taken || w_bubble) begin
      r_if_instr <= NOP_INSTR;
      r_if_pc4   <= '0;
      r_if_valid <= 1'b0;
    end else if (w_load_mem) begin
      r_if_instr <= imem_rdata;
      r_if_pc4   <= w_pc_plus4;
      r_if_valid <= 1'b1;
    end else if (w_load_skid) begin
      r_if_instr <= w_skid_instr;
      r_if_pc4   <= w_skid_pc4;
      r_if_valid <= 1'b1;
    end
  end

  fetch_skid_buffer #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_skid_load),
    .i_clear    (branch_taken),
    .i_instr    (imem_rdata),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (w_skid_instr),
    .o_pc_plus4 (w_skid_pc4)
  );

  assign if_id_instr    = r_if_instr;
  assign if_id_pc_plus4 = r_if_pc4;
  assign if_id_valid    = r_if_valid;
  assign opcode         = r_if_instr[OPC_MSB:OPC_LSB];
  assign func           = r_if_instr[FUNC_MSB:FUNC_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load_mem || w_load_skid) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_bubble || branch_taken)  r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_fetch_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random stall/wait/branch
// traffic, checked against an instruction-stream reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_d;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .stall_d         (stall_d),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .opcode          (opcode),
    .func            (func),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  // Instruction memory contents: fixed words at 0x0/0x4, address hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    if (a == 32'h4) return 32'h0109_5020;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } slot_t;

  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_txn   = 0;

  // Reference model: the fetch unit as a PC plus a queue of fetched-but-undelivered words.
  logic [31:0] m_pc;
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  slot_t       m_pending[$];
  logic [31:0] m_fcnt, m_bcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_pending.delete();
    m_fcnt  = 32'h0;
    m_bcnt  = 32'h0;
  endtask

  task automatic deliver(input slot_t s);
    m_instr = s.instr;
    m_pc4   = s.pc4;
    m_valid = 1'b1;
    m_fcnt  = m_fcnt + 32'd1;
  endtask

  task automatic make_bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_bcnt  = m_bcnt + 32'd1;
  endtask

  // Drive one cycle of inputs and push what the outputs must look like after the edge.
  task automatic step(input bit ready, input bit stall, input bit br, input logic [31:0] tgt);
    slot_t s;
    exp_t  e;
    @(negedge clk);
    imem_ready    = ready;
    stall_d       = stall;
    branch_taken  = br;
    branch_target = tgt;
    if (br) begin
      m_pending.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
      make_bubble();
    end else if (m_pending.size() > 0) begin
      if (!stall) deliver(m_pending.pop_front());
    end else if (ready) begin
      s.instr = mem_word(m_pc);
      s.pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      if (stall) m_pending.push_back(s);
      else       deliver(s);
    end else if (!stall) begin
      make_bubble();
    end
    e.req   = (m_pending.size() == 0);
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_valid;
`ifdef FETCH_PERF_CNT_EN
    e.fcnt  = m_fcnt;
    e.bcnt  = m_bcnt;
`else
    e.fcnt  = 32'h0;
    e.bcnt  = 32'h0;
`endif
    sb_q.push_back(e);
  endtask

  // Monitor: each cycle the DUT presents a fresh IF/ID + fetch request, compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_txn++;
        $display("[TB] txn %0d: req=%0d addr=%08h if_id=%08h pc4=%08h v=%0d",
                 n_txn, imem_req, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid);
        chk("imem_req",        {31'b0, imem_req},    {31'b0, e.req});
        chk("imem_addr",       imem_addr,            e.addr);
        chk("if_id_instr",     if_id_instr,          e.instr);
        chk("if_id_pc_plus4",  if_id_pc_plus4,       e.pc4);
        chk("if_id_valid",     {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("opcode",          {26'b0, opcode},      {26'b0, e.instr[31:26]});
        chk("func",            {26'b0, func},        {26'b0, e.instr[5:0]});
        chk("perf_fetch_cnt",  perf_fetch_cnt,       e.fcnt);
        chk("perf_bubble_cnt", perf_bubble_cnt,      e.bcnt);
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_imem_addr",  imem_addr,            32'h0);
    chk("rst_imem_req",   {31'b0, imem_req},    32'h1);
    chk("rst_if_valid",   {31'b0, if_id_valid}, 32'h0);
    chk("rst_if_instr",   if_id_instr,          32'h0);
    chk("rst_if_pc4",     if_id_pc_plus4,       32'h0);
    chk("rst_perf_fetch", perf_fetch_cnt,       32'h0);
    chk("rst_perf_bub",   perf_bubble_cnt,      32'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ready    = 1'b0;
    stall_d       = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Advance the PC to 0x20, then hit reset mid-cycle and look immediately.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    chk("pre_rst_addr", imem_addr, 32'h20);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming from 0x0 and 0x4.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    // Two wait states at 0x8, then the word arrives.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    // Accept 0xC under stall, hold three more cycles, release, then fetch 0x10.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    // Branch to 0x40 coincident with accept at 0x14 and stall.
    step(1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    // Misaligned target, then wrap at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 32'h43);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    // Branch while holding a skid entry.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          rdy, stl, br;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 9) < 7);
      stl = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
      step(rdy, stl, br, tgt);
    end

    step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Latches the returned word into IF/ID and presents opcode/func directly to the decode-stage control unit.
- Handles load-use stalls from the hazard unit and beq redirects resolved in decode.

Parameters:
PC_WIDTH, 32, width of PC, memory address and pc_plus4.
INSTR_WIDTH, 32, instruction word width.
RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request valid.
imem_addr  out  PC_WIDTH  fetch byte address; bits [1:0] always 0.
imem_rdata  in  INSTR_WIDTH  instruction word; valid in the cycle where imem_req && imem_ready.
imem_ready  in  1  memory accepts the request and returns data in the same cycle.
stall_d  in  1  hold IF/ID (load-use stall).
branch_taken  in  1  redirect the PC and flush IF/ID.
branch_target  in  PC_WIDTH  redirect address; bits [1:0] ignored.
if_id_instr  out  INSTR_WIDTH  IF/ID instruction.
if_id_pc_plus4  out  PC_WIDTH  IF/ID PC+4, for the branch adder.
if_id_valid  out  1  IF/ID holds a real instruction.
opcode  out  6  if_id_instr[31:26], to the control unit.
func  out  6  if_id_instr[5:0], to the control unit.
perf_fetch_cnt  out  32  fetched-instruction count (optional feature).
perf_bubble_cnt  out  32  bubble-cycle count (optional feature).

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - pc = RESET_PC, state = S_REQ.
  - if_id_instr = 0 (NOP, sll $0,$0,0), if_id_pc_plus4 = 0, if_id_valid = 0.
  - Skid buffer cleared; perf counters cleared.
- imem_req = 1 in S_REQ, 0 in S_HOLD. imem_addr = pc at all times.
- accept = imem_req && imem_ready. On accept, pc <= pc + 4, modulo 2^PC_WIDTH (0xFFFFFFFC wraps to 0x0).
- Priority order, evaluated every cycle:
  1. branch_taken:
     - pc <= {branch_target[31:2], 2'b00}.
     - IF/ID <= NOP, valid 0.
     - Skid buffer discarded; state <= S_REQ.
     - Any same-cycle accepted word is dropped.
     - Overrides stall_d.
  2. S_REQ, accept, !stall_d: IF/ID <= {imem_rdata, pc+4}, valid 1. Latency: data is visible on IF/ID one clock after accept.
  3. S_REQ, accept, stall_d: IF/ID holds; skid buffer <= {imem_rdata, pc+4}; state <= S_HOLD.
  4. S_REQ, no accept, !stall_d: IF/ID <= NOP, valid 0 (bubble).
  5. S_REQ, no accept, stall_d: IF/ID holds.
  6. S_HOLD, stall_d: everything holds; no request is issued.
  7. S_HOLD, !stall_d: IF/ID <= skid buffer, valid 1; state <= S_REQ. The request is re-issued at the next cycle.
- No instruction is duplicated or lost across any stall/wait combination.
- opcode and func are combinational slices of if_id_instr. A bubble decodes as R-type func 0 writing $0, which is architecturally harmless; downstream may also gate on if_id_valid.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each IF/ID load with valid 1.
  - perf_bubble_cnt increments on each bubble cycle (case 4) and each flush.
  - Both counters wrap at 2^32.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Package mips_pkg:
  - INSTR_W, PC_W, NOP_INSTR = 32'h0.
  - Opcode/func field positions (OPC_MSB/LSB, FUNC_MSB/LSB).
  - Opcode constants shared with the control unit: R=000000, LW=100011, SW=101011, BEQ=000100.
  - Fetch state enum: S_REQ, S_HOLD.
- Sub-module fetch_skid_buffer: one-entry {instr, pc_plus4} register with load/clear, used for case 3/7.

Test Plan:
1. Reset: assert rst_n=0 mid-fetch with pc=0x20 → pc=0x0, if_id_valid=0, if_id_instr=0 immediately. After release, imem_req=1 with addr 0x0.
2. Streaming, imem_ready=1, words 0x8C080004 then 0x01095020:
   - Cycle 1: opcode=0x23, pc_plus4=0x4.
   - Cycle 2: opcode=0x00, func=0x20, pc_plus4=0x8.
   - if_id_valid=1 throughout.
3. Wait states: imem_ready=0 for 2 cycles at addr 0x8 → two bubbles (valid 0, instr 0) and addr held at 0x8. The word arrives on the third cycle.
4. Stall with accept: stall_d=1 while the word at 0xC is accepted:
   - IF/ID keeps the 0x8 instruction; imem_req=0 for 3 stall cycles.
   - After stall_d drops, IF/ID gets the 0xC word with pc_plus4=0x10, then the request goes to 0x10.
5. Branch: branch_taken=1, target 0x40, in the same cycle as accept at 0x14 (and with stall_d=1):
   - IF/ID becomes NOP/valid 0; next imem_addr=0x40.
   - The 0x14 word never appears in IF/ID.
6. Alignment and wrap:
   - branch_target=0x43 → imem_addr=0x40.
   - pc=0xFFFFFFFC accepted → next imem_addr=0x0 and if_id_pc_plus4=0x0.
   - With FETCH_PERF_CNT_EN defined, the counters match the counts of valid loads and bubbles.
